// File: rtl/wb_arbiter_2.sv
// Two-master to one-slave Wishbone classic arbiter.
// Round-robin grant, locked for the whole CYC of the winning master, with an
// optional watchdog that ends unanswered strobes with a one-cycle ERR.
module wb_arbiter_2 #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT      = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
   input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
   output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
   input  logic                    wbm0_we_i,
   input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
   input  logic                    wbm0_stb_i,
   output logic                    wbm0_ack_o,
   output logic                    wbm0_err_o,
   output logic                    wbm0_rty_o,
   input  logic                    wbm0_cyc_i,
   input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
   input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
   output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
   input  logic                    wbm1_we_i,
   input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
   input  logic                    wbm1_stb_i,
   output logic                    wbm1_ack_o,
   output logic                    wbm1_err_o,
   output logic                    wbm1_rty_o,
   input  logic                    wbm1_cyc_i,
   output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
   input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
   output logic [DATA_WIDTH-1:0]   wbs_dat_o,
   output logic                    wbs_we_o,
   output logic [SELECT_WIDTH-1:0] wbs_sel_o,
   output logic                    wbs_stb_o,
   input  logic                    wbs_ack_i,
   input  logic                    wbs_err_i,
   input  logic                    wbs_rty_i,
   output logic                    wbs_cyc_o
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   // Count value at which an unanswered strobe is cut off
   localparam logic [15:0] WD_LIMIT = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

   state_t      state_q, state_d;
   logic        lastGrant_q, lastGrant_d;
   logic [15:0] wdCount_q, wdCount_d;
   logic        busy, slaveResp, timeoutHit;

   // State, round-robin memory and watchdog counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         wdCount_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         wdCount_q   <= wdCount_d;
      end
   end

   // Next grant: hold while the owner keeps CYC, hand over directly otherwise
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      case (state_q)
         IDLE: begin
            if (wbm0_cyc_i && wbm1_cyc_i) state_d = lastGrant_q ? GRANT0 : GRANT1;
            else if (wbm0_cyc_i)          state_d = GRANT0;
            else if (wbm1_cyc_i)          state_d = GRANT1;
         end
         GRANT0: if (!wbm0_cyc_i) state_d = wbm1_cyc_i ? GRANT1 : IDLE;
         GRANT1: if (!wbm1_cyc_i) state_d = wbm0_cyc_i ? GRANT0 : IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == GRANT0 && state_q != GRANT0) lastGrant_d = 1'b0;
      if (state_d == GRANT1 && state_q != GRANT1) lastGrant_d = 1'b1;
   end

   // Watchdog: count silent strobe cycles of the owner, fire once at the limit
   always_comb begin
      busy       = (state_q == GRANT0 && wbm0_cyc_i && wbm0_stb_i) ||
                   (state_q == GRANT1 && wbm1_cyc_i && wbm1_stb_i);
      slaveResp  = wbs_ack_i || wbs_err_i || wbs_rty_i;
      timeoutHit = (TIMEOUT > 0) && busy && !slaveResp && (wdCount_q == WD_LIMIT);
      wdCount_d  = wdCount_q + 16'd1;
      if (TIMEOUT == 0 || state_d != state_q || !busy || slaveResp || timeoutHit)
         wdCount_d = 16'd0;
   end

   // Bus steering from the registered grant; the loser sees nothing
   always_comb begin
      wbs_adr_o  = '0;
      wbs_dat_o  = '0;
      wbs_we_o   = 1'b0;
      wbs_sel_o  = '0;
      wbs_stb_o  = 1'b0;
      wbs_cyc_o  = 1'b0;
      wbm0_dat_o = '0;
      wbm0_ack_o = 1'b0;
      wbm0_err_o = 1'b0;
      wbm0_rty_o = 1'b0;
      wbm1_dat_o = '0;
      wbm1_ack_o = 1'b0;
      wbm1_err_o = 1'b0;
      wbm1_rty_o = 1'b0;
      case (state_q)
         GRANT0: begin
            wbs_adr_o  = wbm0_adr_i;
            wbs_dat_o  = wbm0_dat_i;
            wbs_we_o   = wbm0_we_i;
            wbs_sel_o  = wbm0_sel_i;
            wbs_cyc_o  = wbm0_cyc_i;
            wbs_stb_o  = wbm0_cyc_i && wbm0_stb_i && !timeoutHit;
            wbm0_dat_o = wbs_dat_i;
            wbm0_ack_o = wbs_ack_i;
            wbm0_err_o = wbs_err_i || timeoutHit;
            wbm0_rty_o = wbs_rty_i;
         end
         GRANT1: begin
            wbs_adr_o  = wbm1_adr_i;
            wbs_dat_o  = wbm1_dat_i;
            wbs_we_o   = wbm1_we_i;
            wbs_sel_o  = wbm1_sel_i;
            wbs_cyc_o  = wbm1_cyc_i;
            wbs_stb_o  = wbm1_cyc_i && wbm1_stb_i && !timeoutHit;
            wbm1_dat_o = wbs_dat_i;
            wbm1_ack_o = wbs_ack_i;
            wbm1_err_o = wbs_err_i || timeoutHit;
            wbm1_rty_o = wbs_rty_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Bench for wb_arbiter_2: two instances (watchdog off / watchdog at 8 cycles)
// share one set of masters and one slave, checked every cycle against an
// ownership-level model plus directed literal checks.
module tb_wb_arbiter_2;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   typedef struct packed {
      logic [AW-1:0] adr;
      logic [DW-1:0] sdat;
      logic          we;
      logic [SW-1:0] sel;
      logic          stb;
      logic          cyc;
      logic [DW-1:0] mdat1;
      logic [DW-1:0] mdat0;
      logic [1:0]    ack;
      logic [1:0]    err;
      logic [1:0]    rty;
   } busView_t;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] mAdr[2];
   logic [DW-1:0] mDatW[2];
   logic          mWe[2];
   logic [SW-1:0] mSel[2];
   logic          mStb[2];
   logic          mCyc[2];
   logic [DW-1:0] sDatR;
   logic          sAck, sErr, sRty;

   logic [AW-1:0] oSAdr[2];
   logic [DW-1:0] oSDat[2];
   logic          oSWe[2];
   logic [SW-1:0] oSSel[2];
   logic          oSStb[2];
   logic          oSCyc[2];
   logic [DW-1:0] oMDat0[2], oMDat1[2];
   logic          oMAck0[2], oMAck1[2], oMErr0[2], oMErr1[2], oMRty0[2], oMRty1[2];

   int total = 0;
   int bad   = 0;

   // Model state per instance: owner -1 = nobody
   int   owner[2];
   int   lastG[2];
   int   silent[2];
   int   limit[2] = '{0, 8};
   logic respSeen[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gDut
      wb_arbiter_2 #(
         .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(g == 0 ? 0 : 8)
      ) dut (
         .clk(clk), .rst_n(rst_n),
         .wbm0_adr_i(mAdr[0]), .wbm0_dat_i(mDatW[0]), .wbm0_dat_o(oMDat0[g]),
         .wbm0_we_i(mWe[0]), .wbm0_sel_i(mSel[0]), .wbm0_stb_i(mStb[0]),
         .wbm0_ack_o(oMAck0[g]), .wbm0_err_o(oMErr0[g]), .wbm0_rty_o(oMRty0[g]),
         .wbm0_cyc_i(mCyc[0]),
         .wbm1_adr_i(mAdr[1]), .wbm1_dat_i(mDatW[1]), .wbm1_dat_o(oMDat1[g]),
         .wbm1_we_i(mWe[1]), .wbm1_sel_i(mSel[1]), .wbm1_stb_i(mStb[1]),
         .wbm1_ack_o(oMAck1[g]), .wbm1_err_o(oMErr1[g]), .wbm1_rty_o(oMRty1[g]),
         .wbm1_cyc_i(mCyc[1]),
         .wbs_adr_o(oSAdr[g]), .wbs_dat_i(sDatR), .wbs_dat_o(oSDat[g]),
         .wbs_we_o(oSWe[g]), .wbs_sel_o(oSSel[g]), .wbs_stb_o(oSStb[g]),
         .wbs_ack_i(sAck), .wbs_err_i(sErr), .wbs_rty_i(sRty), .wbs_cyc_o(oSCyc[g])
      );
   end

   // Every cycle: predict both instances from who owns the bus, compare, advance
   always @(negedge clk) begin
      busView_t e, a;
      int   gOwn, nxt;
      logic busy, resp, hit;
      for (int k = 0; k < 2; k++) begin
         e = '0;
         if (!rst_n) begin
            owner[k] = -1; lastG[k] = 1; silent[k] = 0;
         end else begin
            gOwn = owner[k];
            resp = sAck | sErr | sRty;
            busy = 1'b0;
            hit  = 1'b0;
            if (gOwn >= 0) begin
               busy   = mCyc[gOwn] && mStb[gOwn];
               hit    = (limit[k] > 0) && busy && !resp && (silent[k] == limit[k] - 1);
               e.adr  = mAdr[gOwn];
               e.sdat = mDatW[gOwn];
               e.we   = mWe[gOwn];
               e.sel  = mSel[gOwn];
               e.cyc  = mCyc[gOwn];
               e.stb  = busy && !hit;
               if (gOwn == 0) e.mdat0 = sDatR; else e.mdat1 = sDatR;
               e.ack[gOwn] = sAck;
               e.err[gOwn] = sErr | hit;
               e.rty[gOwn] = sRty;
            end
            nxt = gOwn;
            if (gOwn < 0) begin
               if (mCyc[0] && mCyc[1]) nxt = 1 - lastG[k];
               else if (mCyc[0])       nxt = 0;
               else if (mCyc[1])       nxt = 1;
            end else if (!mCyc[gOwn]) begin
               nxt = mCyc[1 - gOwn] ? 1 - gOwn : -1;
            end
            silent[k] = (gOwn >= 0 && nxt == gOwn && busy && !resp && !hit) ? silent[k] + 1 : 0;
            if (nxt >= 0 && nxt != gOwn) lastG[k] = nxt;
            owner[k] = nxt;
         end
         a.adr = oSAdr[k];  a.sdat = oSDat[k]; a.we = oSWe[k]; a.sel = oSSel[k];
         a.stb = oSStb[k];  a.cyc = oSCyc[k];
         a.mdat1 = oMDat1[k]; a.mdat0 = oMDat0[k];
         a.ack = {oMAck1[k], oMAck0[k]};
         a.err = {oMErr1[k], oMErr0[k]};
         a.rty = {oMRty1[k], oMRty0[k]};
         total++;
         if (a !== e) begin
            bad++;
            $display("[TB] FAIL model_t%0d at %0t: got %h want %h", limit[k], $time, a, e);
         end
         if (k == 1) begin
            respSeen[0] = e.ack[0] | e.err[0] | e.rty[0];
            respSeen[1] = e.ack[1] | e.err[1] | e.rty[1];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                                input logic [SW-1:0] sel);
      mCyc[m] = cyc; mStb[m] = stb; mWe[m] = we; mAdr[m] = adr; mDatW[m] = dat; mSel[m] = sel;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One random cycle of master and slave behaviour
   task automatic randomStep(input bit silentSlave);
      int r;
      sDatR = $urandom;
      r = $urandom_range(0, 9);
      sAck = !silentSlave && r < 3;
      sErr = !silentSlave && r == 3;
      sRty = !silentSlave && r == 4;
      for (int m = 0; m < 2; m++) begin
         if (!mCyc[m]) begin
            if ($urandom_range(0, 3) == 0)
               applyStimulus(m, 1, 1, 1'($urandom), $urandom, $urandom, 4'($urandom));
         end else if (mStb[m]) begin
            if (respSeen[m]) begin
               mStb[m] = 1'b0;
               if ($urandom_range(0, 1) == 0) mCyc[m] = 1'b0;
            end
         end else begin
            r = $urandom_range(0, 3);
            if (r < 2)       applyStimulus(m, 1, 1, 1'($urandom), $urandom, $urandom, 4'($urandom));
            else if (r == 2) mCyc[m] = 1'b0;
         end
      end
   endtask

   initial begin
      int errs0, errs8;
      logic errSeen;
      rst_n = 1'b0;
      sDatR = '0; sAck = 1'b0; sErr = 1'b0; sRty = 1'b0;
      respSeen[0] = 1'b0; respSeen[1] = 1'b0;
      applyStimulus(0, 0, 0, 0, '0, '0, '0);
      applyStimulus(1, 0, 0, 0, '0, '0, '0);
      repeat (3) tick();
      @(negedge clk);
      checkOutput("reset_wbs_cyc", 64'(oSCyc[1]), 0);
      checkOutput("reset_m0_ack", 64'(oMAck0[1]), 0);
      tick(); rst_n = 1'b1; tick();

      // Single write from master 0
      applyStimulus(0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      checkOutput("write_latency_cyc", 64'(oSCyc[1]), 0);
      tick();
      @(negedge clk);
      checkOutput("write_wbs_cyc", 64'(oSCyc[1]), 1);
      checkOutput("write_wbs_adr", 64'(oSAdr[1]), 64'h100);
      checkOutput("write_wbs_dat", 64'(oSDat[1]), 64'hDEADBEEF);
      tick(); sAck = 1'b1;
      @(negedge clk);
      checkOutput("write_m0_ack", 64'(oMAck0[1]), 1);
      checkOutput("write_m1_ack", 64'(oMAck1[1]), 0);
      tick(); sAck = 1'b0; applyStimulus(0, 0, 0, 0, '0, '0, '0);
      tick();

      // Round robin after reset: m0, m1, m0
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      applyStimulus(0, 1, 1, 0, 32'h200, '0, 4'hF);
      applyStimulus(1, 1, 1, 0, 32'h300, '0, 4'hF);
      tick(); sAck = 1'b1;
      @(negedge clk);
      checkOutput("rr_first_m0", 64'(oSAdr[1]), 64'h200);
      tick(); sAck = 1'b0; applyStimulus(0, 0, 0, 0, '0, '0, '0);
      tick(); applyStimulus(0, 1, 1, 0, 32'h204, '0, 4'hF); sAck = 1'b1;
      @(negedge clk);
      checkOutput("rr_second_m1", 64'(oSAdr[1]), 64'h300);
      checkOutput("rr_second_cyc", 64'(oSCyc[1]), 1);
      tick(); sAck = 1'b0; applyStimulus(1, 0, 0, 0, '0, '0, '0);
      tick(); sAck = 1'b1;
      @(negedge clk);
      checkOutput("rr_third_m0", 64'(oSAdr[1]), 64'h204);
      tick(); sAck = 1'b0; applyStimulus(0, 0, 0, 0, '0, '0, '0);
      tick();

      // Master 0 holds CYC over four reads while master 1 waits
      applyStimulus(0, 1, 0, 0, 32'h400, '0, 4'hF);
      tick();
      applyStimulus(1, 1, 1, 0, 32'h500, '0, 4'hF);
      for (int b = 0; b < 4; b++) begin
         applyStimulus(0, 1, 1, 0, 32'h400 + 32'(b * 4), '0, 4'hF);
         sAck = 1'b1;
         @(negedge clk);
         checkOutput("hold_adr", 64'(oSAdr[1]), 64'(32'h400 + 32'(b * 4)));
         checkOutput("hold_m1_ack", 64'(oMAck1[1]), 0);
         tick(); sAck = 1'b0; mStb[0] = 1'b0;
         tick();
      end
      applyStimulus(0, 0, 0, 0, '0, '0, '0);
      tick();
      @(negedge clk);
      checkOutput("hold_handover_m1", 64'(oSAdr[1]), 64'h500);
      tick(); applyStimulus(1, 0, 0, 0, '0, '0, '0);
      tick(); tick();

      // Watchdog on an unanswered master 1 read
      applyStimulus(1, 1, 1, 0, 32'h600, '0, 4'hF);
      tick();
      errSeen = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 8) begin
            checkOutput("wd_m1_err", 64'(oMErr1[1]), 1);
            checkOutput("wd_stb_low", 64'(oSStb[1]), 0);
            checkOutput("wd_m0_err", 64'(oMErr0[1]), 0);
            checkOutput("wd_off_no_err", 64'(oMErr1[0]), 0);
         end else begin
            errSeen = errSeen | oMErr1[1];
         end
         tick();
      end
      checkOutput("wd_no_early_err", 64'(errSeen), 0);
      applyStimulus(1, 0, 0, 0, '0, '0, '0);
      tick(); tick();

      // Slave ack in the expiry cycle wins over the watchdog
      applyStimulus(1, 1, 1, 0, 32'h700, '0, 4'hF);
      tick();
      repeat (7) tick();
      sAck = 1'b1;
      @(negedge clk);
      checkOutput("wd_ack_wins_ack", 64'(oMAck1[1]), 1);
      checkOutput("wd_ack_wins_err", 64'(oMErr1[1]), 0);
      tick(); sAck = 1'b0; applyStimulus(1, 0, 0, 0, '0, '0, '0);
      tick(); tick();

      // 1000 silent strobe cycles: no errors with the watchdog off, 125 with it on
      applyStimulus(1, 1, 1, 0, 32'h800, '0, 4'hF);
      tick();
      errs0 = 0; errs8 = 0;
      repeat (1000) begin
         @(negedge clk);
         errs0 += int'(oMErr0[0]) + int'(oMErr1[0]);
         errs8 += int'(oMErr1[1]);
         tick();
      end
      checkOutput("silent_wd_off_errs", 64'(errs0), 0);
      checkOutput("silent_wd_on_errs", 64'(errs8), 125);
      applyStimulus(1, 0, 0, 0, '0, '0, '0);
      tick(); tick();

      // Reset in the middle of a master 0 write
      applyStimulus(0, 1, 1, 1, 32'h900, 32'h12345678, 4'hF);
      tick(); tick();
      sAck = 1'b1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_cyc", 64'(oSCyc[1]), 0);
      checkOutput("midrst_stb", 64'(oSStb[1]), 0);
      checkOutput("midrst_m0_ack", 64'(oMAck0[1]), 0);
      sAck = 1'b0;
      applyStimulus(1, 1, 1, 0, 32'hA00, '0, 4'hF);
      tick(); rst_n = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("post_reset_m0_first", 64'(oSAdr[1]), 64'h900);
      tick();
      applyStimulus(0, 0, 0, 0, '0, '0, '0);
      applyStimulus(1, 0, 0, 0, '0, '0, '0);
      tick(); tick();

      // Random traffic with alternating responsive / silent slave and rare resets
      for (int n = 0; n < 3000; n++) begin
         rst_n = (n % 700 != 350);
         randomStep(((n / 250) % 2) == 1);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_2.md
Name: wb_arbiter_2

Overview:
Two-master to one-slave Wishbone classic arbiter. It is the counterpart of the address-decoding slave mux: it merges two initiators (for example a CPU and a DMA engine) onto one shared slave port. Grants use round-robin and are locked for the full CYC duration. An optional bus watchdog terminates transactions that the slave never acknowledges with ERR.

Parameters:
DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64)
ADDR_WIDTH, 32, address bus width in bits
SELECT_WIDTH, DATA_WIDTH/8, byte select width
TIMEOUT, 0, watchdog limit in cycles (0 disables; max 65535)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wbm0_adr_i  in  ADDR_WIDTH  master 0 address
wbm0_dat_i  in  DATA_WIDTH  master 0 write data
wbm0_dat_o  out  DATA_WIDTH  master 0 read data
wbm0_we_i  in  1  master 0 write enable
wbm0_sel_i  in  SELECT_WIDTH  master 0 byte select
wbm0_stb_i  in  1  master 0 strobe
wbm0_ack_o  out  1  master 0 acknowledge
wbm0_err_o  out  1  master 0 error
wbm0_rty_o  out  1  master 0 retry
wbm0_cyc_i  in  1  master 0 cycle
wbm1_*  (same ten ports and widths as wbm0_*)  master 1
wbs_adr_o  out  ADDR_WIDTH  slave address
wbs_dat_i  in  DATA_WIDTH  slave read data
wbs_dat_o  out  DATA_WIDTH  slave write data
wbs_we_o  out  1  slave write enable
wbs_sel_o  out  SELECT_WIDTH  slave byte select
wbs_stb_o  out  1  slave strobe
wbs_ack_i  in  1  slave acknowledge
wbs_err_i  in  1  slave error
wbs_rty_i  in  1  slave retry
wbs_cyc_o  out  1  slave cycle

Behaviour:
- Reset: clk and rst_n are the block's only clock and reset; rst_n is asynchronous and active-low. Reset forces state IDLE, last_grant=1 (so master 0 wins the first tie), and clears the watchdog counter. All outputs are 0 while reset is asserted and in IDLE.
- States and transitions:
  - IDLE to GRANT0/GRANT1: taken on the next clk edge when a master's cyc_i is high.
  - Both requesting: the master other than last_grant wins.
  - last_grant updates on entry to a GRANT state.
  - Arbitration latency is 1 cycle from cyc_i rising to wbs_cyc_o rising.
  - GRANTn hold: the state holds while wbmn_cyc_i=1. The grant is never preempted, even when the other master is requesting.
  - GRANTn release: when wbmn_cyc_i=0 is sampled, the next state is GRANT(other) if the other master's cyc_i=1, otherwise IDLE. There is no idle bubble on handover.
- Datapath is combinational from the registered state:
  - wbs_adr/dat/we/sel/stb/cyc_o follow the granted master. wbs_cyc_o and wbs_stb_o are also gated by that master's current cyc_i, so they drop in the same cycle cyc_i drops.
  - In IDLE, all wbs_* outputs are 0.
- Granted master: sees wbs_dat_i and ack/err/rty from the slave. Its err_o is OR'd with the watchdog pulse.
- Non-granted master: dat_o=0, ack_o=0, err_o=0, rty_o=0. Its stb/cyc are held off the bus (it waits).
- Watchdog (TIMEOUT>0 only):
  - Counter: 16-bit. Increments each cycle the granted master has cyc&stb=1 and the slave gives no ack, err or rty. It clears on any slave response, on a state change, or on stb low.
  - Expiry: when the count reaches TIMEOUT-1, the block asserts err_o to the granted master for exactly that one cycle, drives wbs_stb_o=0 in that cycle, and clears the counter.
  - Responses after expiry: slave ack/err/rty arriving after expiry pass through unchanged.
- Simultaneous events:
  - Slave ack in the same cycle as expiry: the ack wins; err is suppressed and the counter clears.
  - Both masters raising cyc in the same cycle: resolved by round-robin.
- Reset mid-transaction: asserting rst_n low immediately drops wbs_cyc_o/stb_o and all master response outputs to 0. There is no completion handshake.

Test Plan:
- Reset, then m0 cyc/stb write adr=0x100 dat=0xDEADBEEF sel=0xF -> wbs_cyc_o rises 1 cycle later; wbs_adr_o=0x100, wbs_dat_o=0xDEADBEEF; slave ack returns on wbm0_ack_o only; wbm1_ack_o=0.
- m0 and m1 assert cyc in the same cycle, three times back-to-back (each drops cyc after ack) -> grant order is m0, m1, m0; handover has no IDLE cycle.
- m0 holds cyc across 4 single-beat reads (stb pulses) while m1 requests -> m1 is not granted until m0 drops cyc; m1 is granted the cycle after.
- TIMEOUT=8, slave never responds to an m1 read -> wbm1_err_o is high for exactly 1 cycle, 8 cycles after stb is first presented on the slave; wbs_stb_o=0 that cycle; m0 stays unaffected.
- TIMEOUT=8, slave acks in exactly the expiry cycle -> wbm_ack_o=1, err_o=0. Separately, with TIMEOUT=0 and 1000 silent cycles -> no err is generated.
- rst_n pulsed low mid-write with m0 granted -> all outputs 0 immediately. After release with both masters requesting -> m0 is granted first, because last_grant resets to 1.
